apb_bridge: RTL and testbench

Converts the core's single-outstanding peripheral bus (`bus_valid`/`bus_ready`) into an APB3 master transfer to one of `NUM_SLAVES` peripherals. It sits directly downstream of `nexusV_core`'s `bus_*` ports, which cover the APB region with `addr[31]=1`. The block adds slave decoding, wait-state handling, `pslverr` reporting and a hang timeout. Its `bus_ready` drives the core's `mem_ready` stall.

---
 rtl/apb_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge.sv
// Bridge from the core's single-outstanding valid/ready bus to an APB3 master.
// Decodes the slave index from the address, handles wait states, slave errors and hung slaves.
module apb_bridge #(
  parameter int NUM_SLAVES = 4,
  parameter int SLV_SHIFT  = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic                    bus_write,
  input  logic                    bus_valid,
  output logic [31:0]             bus_rdata,
  output logic                    bus_ready,
  output logic                    bus_err,
  output logic [NUM_SLAVES-1:0]   psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [31:0]             paddr,
  output logic [31:0]             pwdata,
  input  logic [NUM_SLAVES*32-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]   pready,
  input  logic [NUM_SLAVES-1:0]   pslverr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          write_reg, write_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          err_reg, err_next;

  logic [3:0]    idx_in;
  logic          sel_active;
  logic [31:0]   sel_rdata;
  logic          sel_ready;
  logic          sel_err;

  assign idx_in = bus_addr[SLV_SHIFT+3:SLV_SHIFT];

  // Only the addressed slave's response lines are looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_reg == 4'(i)) begin
        sel_rdata = prdata[i*32 +: 32];
        sel_ready = pready[i];
        sel_err   = pslverr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      write_reg <= write_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    write_next = write_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus_valid) begin
          addr_next  = bus_addr;
          wdata_next = bus_wdata;
          write_next = bus_write;
          idx_next   = idx_in;
          if (int'(idx_in) < NUM_SLAVES) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_next = RESP;
          err_next   = sel_err;
          rdata_next = (!write_reg && !sel_err) ? sel_rdata : '0;
        end else if (cnt_reg == CNT_LAST) begin
          // Hung slave: abandon the transfer and report an error to the core.
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel_active = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable    = (state_reg == ACCESS);
  assign bus_ready  = (state_reg == RESP);
  assign bus_rdata  = bus_ready ? rdata_reg : '0;
  assign bus_err    = bus_ready & err_reg;
  assign paddr      = addr_reg;
  assign pwdata     = wdata_reg;
  assign pwrite     = write_reg;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
    assign psel[gi] = sel_active && (idx_reg == 4'(gi));
  end

endmodule

// File: tb/tb_apb_bridge.sv
// Randomized and directed bench for apb_bridge; expectations come from a transaction-level
// model (response cycle, access-phase window, returned data) derived from each request's plan.
module tb_apb_bridge;
  localparam int NS = 4;
  localparam int SH = 12;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, paddr, pwdata;
  logic bus_write, bus_valid, bus_ready, bus_err, penable, pwrite;
  logic [NS-1:0] psel, pready, pslverr;
  logic [NS*32-1:0] prdata;

  always #5 clk = ~clk;

  apb_bridge #(.NUM_SLAVES(NS), .SLV_SHIFT(SH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_valid(bus_valid),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Transaction plan and the model's derived expectations.
  logic [31:0] p_addr, p_wdata, p_data;
  logic        p_write, p_err;
  int          p_w, p_idx, p_acc, p_resp;
  bit          p_mapped, p_timeout;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          txn_active = 0;
  int          cyc;

  // Observations fed to the literal checks.
  int          obs_ready_cyc, obs_access;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [NS-1:0] obs_psel1;

  logic [NS-1:0] exp_psel;
  bit in_apb;

  always @(negedge clk) begin
    if (txn_active) begin
      in_apb   = p_mapped && cyc >= 1 && cyc < p_resp;
      exp_psel = in_apb ? NS'(1 << p_idx) : '0;
      chk("psel", psel, exp_psel);
      chk("penable", penable, in_apb && cyc >= 2);
      chk("bus_ready", bus_ready, cyc == p_resp);
      if (cyc == p_resp) begin
        chk("bus_rdata", bus_rdata, exp_rdata);
        chk("bus_err", bus_err, exp_err);
      end
      if (in_apb) begin
        chk("paddr", paddr, p_addr);
        chk("pwdata", pwdata, p_wdata);
        chk("pwrite", pwrite, p_write);
      end
      if (cyc == 1) obs_psel1 = psel;
      if (penable) obs_access++;
      if (bus_ready && obs_ready_cyc < 0) begin
        obs_ready_cyc = cyc;
        obs_rdata     = bus_rdata;
        obs_err       = bus_err;
      end
    end
  end

  task automatic drive(input int c);
    for (int i = 0; i < NS; i++) begin
      if (p_mapped && i == p_idx) begin
        pready[i]          = (c >= 2 + p_w);
        pslverr[i]         = p_err;
        prdata[i*32 +: 32] = p_data;
      end else begin
        pready[i]          = 1'($urandom);
        pslverr[i]         = 1'($urandom);
        prdata[i*32 +: 32] = $urandom;
      end
    end
    bus_valid = (c <= p_resp);
    bus_addr  = p_addr;
    bus_wdata = p_wdata;
    bus_write = p_write;
  endtask

  // Starts at posedge+1 and returns at posedge+1; rst_cyc >= 0 asserts reset in that cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input int w, input logic err, input logic [31:0] data, input int rst_cyc);
    int last;
    p_addr = addr; p_wdata = wdata; p_write = wr; p_w = w; p_err = err; p_data = data;
    p_idx     = int'((addr >> SH) & 32'hF);
    p_mapped  = p_idx < NS;
    p_timeout = p_mapped && (w >= TO);
    p_acc     = !p_mapped ? 0 : (p_timeout ? TO : w + 1);
    p_resp    = p_mapped ? 2 + p_acc : 1;
    exp_err   = !p_mapped || p_timeout || err;
    exp_rdata = (p_mapped && !p_timeout && !wr && !err) ? data : 32'h0;
    obs_ready_cyc = -1; obs_access = 0; obs_rdata = 'x; obs_err = 1'bx; obs_psel1 = 'x;
    last = (rst_cyc >= 0) ? rst_cyc : p_resp + 1;
    txn_active = 1;
    for (int c = 0; c <= last; c++) begin
      cyc = c;
      drive(c);
      if (c == rst_cyc) rst = 1'b1;
      @(posedge clk); #1;
    end
    txn_active = 0;
    $display("txn addr=%h wr=%0d wait=%0d err=%0d -> ready@%0d rdata=%h err=%0d",
             addr, wr, w, err, obs_ready_cyc, obs_rdata, obs_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, psel, '0);
    chk({tag, "_penable"}, penable, 1'b0);
    chk({tag, "_ready"}, bus_ready, 1'b0);
    chk({tag, "_err"}, bus_err, 1'b0);
    chk({tag, "_rdata"}, bus_rdata, 32'h0);
    chk({tag, "_paddr"}, paddr, 32'h0);
    chk({tag, "_pwdata"}, pwdata, 32'h0);
    chk({tag, "_pwrite"}, pwrite, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int w;
    rst = 1'b1; bus_valid = 1'b0; bus_addr = '0; bus_wdata = '0; bus_write = 1'b0;
    pready = '0; pslverr = '0; prdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(32'h8000_1004, 32'h0, 1'b0, 0, 1'b0, 32'h1234_5678, -1);
    chk("zw_ready_cyc", 64'(obs_ready_cyc), 64'd3);
    chk("zw_rdata", obs_rdata, 32'h1234_5678);
    chk("zw_err", obs_err, 1'b0);
    chk("zw_psel1", obs_psel1, 4'b0010);

    run_txn(32'h8000_0010, 32'hA5A5_0001, 1'b1, 3, 1'b0, 32'hDEAD_BEEF, -1);
    chk("wr_ready_cyc", 64'(obs_ready_cyc), 64'd6);
    chk("wr_rdata", obs_rdata, 32'h0);
    chk("wr_access", 64'(obs_access), 64'd4);

    run_txn(32'h8000_2000, 32'h0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, -1);
    chk("se_err", obs_err, 1'b1);
    chk("se_rdata", obs_rdata, 32'h0);
    chk("se_ready_cyc", 64'(obs_ready_cyc), 64'd3);

    run_txn(32'h8000_5000, 32'h0, 1'b0, 0, 1'b0, 32'h0, -1);
    chk("um_ready_cyc", 64'(obs_ready_cyc), 64'd1);
    chk("um_err", obs_err, 1'b1);
    chk("um_access", 64'(obs_access), 64'd0);

    run_txn(32'h8000_3008, 32'h0, 1'b0, 1000, 1'b0, 32'h5555_AAAA, -1);
    chk("to_ready_cyc", 64'(obs_ready_cyc), 64'd10);
    chk("to_access", 64'(obs_access), 64'd8);
    chk("to_err", obs_err, 1'b1);
    run_txn(32'h8000_3008, 32'h0, 1'b0, 1, 1'b0, 32'h0BAD_F00D, -1);
    chk("after_to_rdata", obs_rdata, 32'h0BAD_F00D);

    run_txn(32'h8000_0020, 32'h1111_2222, 1'b1, 100, 1'b0, 32'h0, 3);
    chk_all_zero("midrst");
    rst = 1'b0; bus_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_ready", bus_ready, 1'b0);
    run_txn(32'h8000_1000, 32'h0, 1'b0, 0, 1'b0, 32'hCAFE_0001, -1);
    chk("rr_ready_cyc", 64'(obs_ready_cyc), 64'd3);
    chk("rr_rdata", obs_rdata, 32'hCAFE_0001);

    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      a[31] = 1'b1;
      a[SH+3:SH] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NS-1));
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 4);
      run_txn(a, $urandom, 1'($urandom), w, 1'($urandom_range(0, 5) == 0), $urandom, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
